// File: rtl/simple_cpu_pkg.sv
// rtl/simple_cpu_pkg.sv - shared instruction-memory geometry and loader state encoding
package simple_cpu_pkg;

  localparam int INSTR_W     = 12;
  localparam int IMEM_ADDR_W = 3;
  localparam int IMEM_DEPTH  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    FLUSH = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - streams program words into instruction memory slots 0..DEPTH-1
// Optional readback verification of every written word under LOADER_VERIFY_EN.
module instruction_loader
  import simple_cpu_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_word,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W + 1)'(DEPTH - 1);

  loader_state_t     r_state, w_state_nx;
  logic [ADDR_W-1:0] r_index, w_index_nx;
  logic [DATA_W-1:0] r_wdata, w_wdata_nx;
  logic              r_load, w_load_nx;
  logic              r_busy;
  logic              r_done, w_done_nx;
  logic [ADDR_W:0]   r_count, w_count_nx;
  logic              w_hs;

  assign in_ready = (r_state == WRITE);
  // count never passes DEPTH: WRITE is left on the handshake that reaches it
  assign w_hs     = in_ready && in_valid && (r_count < LP_DEPTH);

`ifdef LOADER_VERIFY_EN
  logic r_error, w_error_nx;
  assign error = r_error;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
  assign error          = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_index_nx = r_index;
    w_wdata_nx = r_wdata;
    w_load_nx  = 1'b0;
    w_done_nx  = 1'b0;
    w_count_nx = r_count;
`ifdef LOADER_VERIFY_EN
    w_error_nx = r_error;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nx = WRITE;
          w_count_nx = '0;
`ifdef LOADER_VERIFY_EN
          w_error_nx = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (w_hs) begin
          w_load_nx  = 1'b1;
          w_index_nx = r_count[ADDR_W-1:0];
          w_wdata_nx = in_word;
          w_count_nx = r_count + 1'b1;
`ifdef LOADER_VERIFY_EN
          w_state_nx = FLUSH;
`else
          if (r_count == LP_LAST) w_state_nx = FLUSH;
`endif
        end
      end
      FLUSH: begin
`ifdef LOADER_VERIFY_EN
        w_state_nx = CHECK;
`else
        w_state_nx = DONE;
        w_done_nx  = 1'b1;
`endif
      end
`ifdef LOADER_VERIFY_EN
      CHECK: begin
        // memory read is combinational on mem_index, which still holds the slot just written
        if (mem_rdata != r_wdata) w_error_nx = 1'b1;
        if (r_count == LP_DEPTH) begin
          w_state_nx = DONE;
          w_done_nx  = 1'b1;
        end else begin
          w_state_nx = WRITE;
        end
      end
`endif
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index <= '0;
      r_wdata <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_index <= w_index_nx;
      r_wdata <= w_wdata_nx;
      r_load  <= w_load_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_done  <= w_done_nx;
      r_count <= w_count_nx;
    end
  end

`ifdef LOADER_VERIFY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_error_nx;
    end
  end
`endif

  assign mem_index = r_index;
  assign mem_wdata = r_wdata;
  assign mem_load  = r_load;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed vector bench for instruction_loader with a modelled instruction memory
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_word = '0;
  logic        in_ready;
  logic [2:0]  mem_index;
  logic [11:0] mem_wdata;
  logic        mem_load;
  logic [11:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  count;

  logic [11:0] mem [0:7];
  logic        corrupt_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_load) mem[mem_index] <= mem_wdata;
  assign mem_rdata = (corrupt_en && mem_index == 3'd3) ? 12'hFFF : mem[mem_index];

  instruction_loader dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_word  (in_word),
    .in_ready (in_ready),
    .mem_index(mem_index),
    .mem_wdata(mem_wdata),
    .mem_load (mem_load),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .count    (count)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [11:0] word;
    logic        load;
    logic [2:0]  index;
    logic [11:0] wdata;
    logic [3:0]  cnt;
    logic        ready;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {9'd0, mem_load, mem_index, mem_wdata, count, in_ready, busy, done};
  endfunction

  function automatic logic [31:0] pack_exp(vec_t v);
    return {9'd0, v.load, v.index, v.wdata, v.cnt, v.ready, v.bsy, v.dn};
  endfunction

  function automatic logic [11:0] w2(int i);
    return 12'h200 + 12'(i * 'h11);
  endfunction

  task automatic push(input logic s, input logic v, input logic [11:0] w, input logic l,
                      input logic [2:0] ix, input logic [11:0] wd, input logic [3:0] c,
                      input logic r, input logic b, input logic d);
    vec_t e;
    e.start = s; e.valid = v; e.word = w; e.load = l; e.index = ix;
    e.wdata = wd; e.cnt = c; e.ready = r; e.bsy = b; e.dn = d;
    vt.push_back(e);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      start    = vt[k].start;
      in_valid = vt[k].valid;
      in_word  = vt[k].word;
      @(negedge clk);
      check($sformatf("vec%0d", k), obs(), pack_exp(vt[k]));
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Full session with word 3 corrupted on readback; returns handshake span and done latency.
  task automatic stream_session(output int span, output int lat);
    int widx;
    int cyc;
    int first;
    int last;
    widx  = 0; cyc = 0; first = -1; last = -1; lat = -1;
    corrupt_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (widx < 8 && cyc < 100) begin
      in_valid = 1'b1;
      in_word  = 12'h600 + 12'(widx);
      if (in_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
        widx++;
      end
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
    end
    check("session_words", 32'(widx), 32'd8);
    for (int t = 1; t <= 10 && lat < 0; t++) begin
      if (done) lat = t;
      else @(negedge clk);
    end
    span = last - first;
    corrupt_en = 1'b0;
  endtask

  initial begin
    int span;
    int lat;
    int done_seen;

    // test 2 / 4: full back-to-back session, then start/in_valid during FLUSH and DONE
    push(1, 0, 12'h000, 0, 3'd0, 12'h000, 4'd0, 1, 1, 0);
    for (int i = 0; i < 8; i++)
      push(0, 1, w2(i), 1, 3'(i), w2(i), 4'(i + 1), (i < 7), 1, 0);
    push(1, 1, 12'hABC, 0, 3'd7, w2(7), 4'd8, 0, 1, 1);
    push(1, 1, 12'hABC, 0, 3'd7, w2(7), 4'd8, 0, 0, 0);
    push(0, 0, 12'h000, 0, 3'd7, w2(7), 4'd8, 0, 0, 0);
    // test 3: in_valid 1,0,0,1 then idle; loader stays in WRITE
    push(1, 0, 12'h000, 0, 3'd7, w2(7), 4'd0, 1, 1, 0);
    push(0, 1, 12'h3A1, 1, 3'd0, 12'h3A1, 4'd1, 1, 1, 0);
    push(0, 0, 12'h000, 0, 3'd0, 12'h3A1, 4'd1, 1, 1, 0);
    push(0, 0, 12'h000, 0, 3'd0, 12'h3A1, 4'd1, 1, 1, 0);
    push(0, 1, 12'h3B2, 1, 3'd1, 12'h3B2, 4'd2, 1, 1, 0);
    push(0, 0, 12'h000, 0, 3'd1, 12'h3B2, 4'd2, 1, 1, 0);

    repeat (2) @(negedge clk);
    check("reset_outputs", obs(), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", obs(), 32'd0);

`ifndef LOADER_VERIFY_EN
    run_table(0, 12);
    for (int i = 0; i < 8; i++) check($sformatf("mem%0d", i), 32'(mem[i]), 32'(w2(i)));
    run_table(12, 18);

    // test 1: reset while a word is on the load path
    in_valid = 1'b1;
    in_word  = 12'h5A5;
    @(posedge clk);
    #1;
    check("load_before_reset", {31'd0, mem_load}, 32'd1);
    check("index_before_reset", 32'(mem_index), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", obs(), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no_done_after_reset", 32'(done_seen), 32'd0);
    check("partial_mem0", 32'(mem[0]), 32'h3A1);
    check("partial_mem1", 32'(mem[1]), 32'h3B2);
    check("partial_mem2", 32'(mem[2]), 32'(w2(2)));
`endif

    // test 5 / 6: readback corruption on word 3
    stream_session(span, lat);
`ifdef LOADER_VERIFY_EN
    check("verify_span", 32'(span), 32'd21);
    check("verify_done_latency", 32'(lat), 32'd3);
    check("verify_error_set", 32'(error), 32'd1);
    @(negedge clk);
    check("verify_error_sticky", 32'(error), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("verify_error_cleared", 32'(error), 32'd0);
`else
    check("plain_span", 32'(span), 32'd7);
    check("plain_done_latency", 32'(lat), 32'd2);
    check("plain_error_zero", 32'(error), 32'd0);
`endif
    check("session_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("smem%0d", i), 32'(mem[i]), 32'h600 + 32'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
